// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: per-slot operand/destination fields in, issue
// decisions and bypass selects out. Widths derive from the same parameters as the scoreboard.
interface issue_scoreboard_if #(
  parameter int ISSUE_W  = 2,
  parameter int WB_DEPTH = 4,
  parameter int LAT_W    = 3
);
  localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int STG_W  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CNT_W  = $clog2(ISSUE_W + 1);

  logic [ISSUE_W-1:0]            id_valid;
  logic [ISSUE_W*5-1:0]          id_rs;
  logic [ISSUE_W*5-1:0]          id_rt;
  logic [ISSUE_W-1:0]            id_read_rs;
  logic [ISSUE_W-1:0]            id_read_rt;
  logic [ISSUE_W-1:0]            id_regwrite;
  logic [ISSUE_W*5-1:0]          id_wreg;
  logic [ISSUE_W*LAT_W-1:0]      id_lat;
  logic                          pipe_stall;
  logic                          flush;
  logic [ISSUE_W-1:0]            issue_ok;
  logic [CNT_W-1:0]              issue_cnt;
  logic                          stall_D;
  logic [2*ISSUE_W-1:0]          fwd_vld;
  logic [2*ISSUE_W*SLOT_W-1:0]   fwd_slot;
  logic [2*ISSUE_W*STG_W-1:0]    fwd_stage;
  logic [31:0]                   hz_stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_read_rs, id_read_rt, id_regwrite, id_wreg, id_lat,
           pipe_stall, flush,
    input  issue_ok, issue_cnt, stall_D, fwd_vld, fwd_slot, fwd_stage, hz_stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_read_rs, id_read_rt, id_regwrite, id_wreg, id_lat,
           pipe_stall, flush,
    output issue_ok, issue_cnt, stall_D, fwd_vld, fwd_slot, fwd_stage, hz_stall_cycles
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Per-register scoreboard for the in-order issue stage: gates each slot on RAW
// hazards and selects the bypass source (slot, stage) for every source operand.
module issue_scoreboard #(
  parameter int ISSUE_W  = 2,
  parameter int NREG     = 32,
  parameter int WB_DEPTH = 4,
  parameter int LAT_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  issue_scoreboard_if.slave  sb
);
  localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam int STG_W  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int WBC_W  = $clog2(WB_DEPTH + 1);
  localparam int CNT_W  = $clog2(ISSUE_W + 1);

  logic              r_busy [NREG];
  logic [SLOT_W-1:0] r_slot [NREG];
  logic [LAT_W-1:0]  r_rdy  [NREG];
  logic [WBC_W-1:0]  r_wb   [NREG];
  logic [31:0]       r_hz;

  logic [ISSUE_W-1:0]          w_issue_ok;
  logic [CNT_W-1:0]            w_cnt;
  logic                        w_stall_d;
  logic                        w_prefix;
  logic                        w_haz;
  logic                        w_rd;
  logic [4:0]                  w_reg;
  logic [4:0]                  w_freg;
  logic [2*ISSUE_W-1:0]        w_fwd_vld;
  logic [2*ISSUE_W*SLOT_W-1:0] w_fwd_slot;
  logic [2*ISSUE_W*STG_W-1:0]  w_fwd_stage;

  // Initial ready countdown; out-of-range latencies fall back to the full pipe depth.
  function automatic logic [LAT_W-1:0] rdy_init(input logic [LAT_W-1:0] lat);
    if (lat == '0 || int'(lat) > WB_DEPTH)
      return LAT_W'(WB_DEPTH - 1);
    return lat - LAT_W'(1);
  endfunction

  function automatic logic [LAT_W-1:0] rdy_dec(input logic [LAT_W-1:0] rdy);
    return (rdy == '0) ? '0 : rdy - LAT_W'(1);
  endfunction

  // ---- D stage: hazard check and in-order issue prefix ----
  always_comb begin
    w_issue_ok = '0;
    w_cnt      = '0;
    w_haz      = 1'b0;
    w_rd       = 1'b0;
    w_reg      = '0;
    w_prefix   = ~sb.pipe_stall & ~sb.flush;
    for (int k = 0; k < ISSUE_W; k++) begin
      w_haz = 1'b0;
      for (int o = 0; o < 2; o++) begin
        w_reg = (o == 0) ? sb.id_rs[k*5 +: 5] : sb.id_rt[k*5 +: 5];
        w_rd  = (o == 0) ? sb.id_read_rs[k] : sb.id_read_rt[k];
        if (w_rd && w_reg != 5'd0) begin
          if (r_busy[w_reg] && r_rdy[w_reg] != '0)
            w_haz = 1'b1;
          // An older slot in the same bundle has no bypass path yet.
          for (int j = 0; j < k; j++)
            if (sb.id_valid[j] && sb.id_regwrite[j] && sb.id_wreg[j*5 +: 5] == w_reg)
              w_haz = 1'b1;
        end
      end
      w_prefix      = w_prefix & sb.id_valid[k] & ~w_haz;
      w_issue_ok[k] = w_prefix;
      w_cnt         = w_cnt + CNT_W'(w_prefix);
    end
  end

  assign w_stall_d = sb.id_valid[0] & ~w_issue_ok[0];

  // Bypass select: a forwardable in-flight write sits at stage WB_DEPTH - wb.
  always_comb begin
    w_fwd_vld   = '0;
    w_fwd_slot  = '0;
    w_fwd_stage = '0;
    w_freg      = '0;
    for (int idx = 0; idx < 2*ISSUE_W; idx++) begin
      w_freg = (idx % 2 == 0) ? sb.id_rs[(idx/2)*5 +: 5] : sb.id_rt[(idx/2)*5 +: 5];
      if (w_freg != 5'd0 && r_busy[w_freg] && r_rdy[w_freg] == '0) begin
        w_fwd_vld[idx]                    = 1'b1;
        w_fwd_slot[idx*SLOT_W +: SLOT_W]  = r_slot[w_freg];
        w_fwd_stage[idx*STG_W +: STG_W]   = STG_W'(WB_DEPTH - int'(r_wb[w_freg]));
      end
    end
  end

  assign sb.issue_ok        = w_issue_ok;
  assign sb.issue_cnt       = w_cnt;
  assign sb.stall_D         = w_stall_d;
  assign sb.fwd_vld         = w_fwd_vld;
  assign sb.fwd_slot        = w_fwd_slot;
  assign sb.fwd_stage       = w_fwd_stage;
  assign sb.hz_stall_cycles = r_hz;

  // ---- E boundary: scoreboard state update ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_busy[r] <= 1'b0;
        r_slot[r] <= '0;
        r_rdy[r]  <= '0;
        r_wb[r]   <= '0;
      end
      r_hz <= '0;
    end else begin
      if (w_stall_d && !sb.pipe_stall && !sb.flush)
        r_hz <= r_hz + 32'd1;
      if (sb.flush) begin
        // E..M2 entries are killed and the W entry retires: either way nothing stays busy.
        for (int r = 0; r < NREG; r++) begin
          if (r_busy[r]) begin
            r_busy[r] <= 1'b0;
            r_rdy[r]  <= '0;
            r_wb[r]   <= '0;
          end
        end
      end else if (!sb.pipe_stall) begin
        for (int r = 0; r < NREG; r++) begin
          if (r_busy[r]) begin
            r_rdy[r] <= rdy_dec(r_rdy[r]);
            r_wb[r]  <= r_wb[r] - WBC_W'(1);
            if (r_wb[r] == WBC_W'(1))
              r_busy[r] <= 1'b0;
          end
        end
        // Later assignments win: new writes override retires, younger slot wins WAW.
        for (int k = 0; k < ISSUE_W; k++) begin
          if (w_issue_ok[k] && sb.id_regwrite[k] && sb.id_wreg[k*5 +: 5] != 5'd0) begin
            r_busy[sb.id_wreg[k*5 +: 5]] <= 1'b1;
            r_slot[sb.id_wreg[k*5 +: 5]] <= SLOT_W'(k);
            r_rdy[sb.id_wreg[k*5 +: 5]]  <= rdy_init(sb.id_lat[k*LAT_W +: LAT_W]);
            r_wb[sb.id_wreg[k*5 +: 5]]   <= WBC_W'(WB_DEPTH);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus a randomized run against an
// age-based reference model (each in-flight write tracked by its issue time and latency).
module tb_issue_scoreboard;
  localparam int ISSUE_W  = 2;
  localparam int NREG     = 32;
  localparam int WB_DEPTH = 4;
  localparam int LAT_W    = 3;
  localparam int SLOT_W   = 1;
  localparam int STG_W    = 2;
  localparam int CNT_W    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.ISSUE_W(ISSUE_W), .WB_DEPTH(WB_DEPTH), .LAT_W(LAT_W)) sbif();

  issue_scoreboard #(.ISSUE_W(ISSUE_W), .NREG(NREG), .WB_DEPTH(WB_DEPTH), .LAT_W(LAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a write is in flight for WB_DEPTH advancing cycles after issue
  // and becomes forwardable once its age reaches lat-1.
  bit          m_v    [NREG];
  int          m_t    [NREG];
  int          m_lat  [NREG];
  int          m_slot [NREG];
  int          adv;
  logic [31:0] m_hz;

  logic [ISSUE_W-1:0]          e_ok;
  logic [CNT_W-1:0]            e_cnt;
  logic                        e_stall;
  logic [2*ISSUE_W-1:0]        e_fv;
  logic [2*ISSUE_W*SLOT_W-1:0] e_fs;
  logic [2*ISSUE_W*STG_W-1:0]  e_fg;

  function automatic int age(int r);
    return adv - m_t[r];
  endfunction
  function automatic bit m_busy(int r);
    return r != 0 && m_v[r] && age(r) < WB_DEPTH;
  endfunction
  function automatic bit m_fwd(int r);
    return m_busy(r) && age(r) >= m_lat[r] - 1;
  endfunction
  function automatic int op_reg(int k, int o);
    return (o == 0) ? int'(sbif.id_rs[k*5 +: 5]) : int'(sbif.id_rt[k*5 +: 5]);
  endfunction
  function automatic int wreg(int k);
    return int'(sbif.id_wreg[k*5 +: 5]);
  endfunction
  function automatic int norm_lat(int l);
    return (l == 0 || l > WB_DEPTH) ? WB_DEPTH : l;
  endfunction

  task automatic model_eval();
    bit go = !sbif.pipe_stall && !sbif.flush;
    e_ok = '0; e_cnt = '0; e_fv = '0; e_fs = '0; e_fg = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      bit haz = 0;
      for (int o = 0; o < 2; o++) begin
        int r  = op_reg(k, o);
        bit rd = (o == 0) ? sbif.id_read_rs[k] : sbif.id_read_rt[k];
        if (rd && r != 0) begin
          if (m_busy(r) && !m_fwd(r)) haz = 1;
          for (int j = 0; j < k; j++)
            if (sbif.id_valid[j] && sbif.id_regwrite[j] && wreg(j) == r) haz = 1;
        end
        if (m_fwd(r)) begin
          e_fv[2*k+o] = 1'b1;
          e_fs[(2*k+o)*SLOT_W +: SLOT_W] = SLOT_W'(m_slot[r]);
          e_fg[(2*k+o)*STG_W +: STG_W]   = STG_W'(age(r));
        end
      end
      go = go && sbif.id_valid[k] && !haz;
      e_ok[k] = go;
      if (go) e_cnt = e_cnt + CNT_W'(1);
    end
    e_stall = sbif.id_valid[0] && !e_ok[0];
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) m_v[r] = 0;
      adv  = 0;
      m_hz = '0;
    end else begin
      if (e_stall && !sbif.pipe_stall && !sbif.flush) m_hz = m_hz + 32'd1;
      if (sbif.flush) begin
        for (int r = 0; r < NREG; r++) m_v[r] = 0;
      end else if (!sbif.pipe_stall) begin
        adv++;
        for (int k = 0; k < ISSUE_W; k++) begin
          if (e_ok[k] && sbif.id_regwrite[k] && wreg(k) != 0) begin
            m_v[wreg(k)]    = 1;
            m_t[wreg(k)]    = adv;
            m_lat[wreg(k)]  = norm_lat(int'(sbif.id_lat[k*LAT_W +: LAT_W]));
            m_slot[wreg(k)] = k;
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_slot(int k, bit v, int rs, bit rrs, int rt, bit rrt, bit we, int wr, int lat);
    sbif.id_valid[k]             = v;
    sbif.id_rs[k*5 +: 5]         = 5'(rs);
    sbif.id_read_rs[k]           = rrs;
    sbif.id_rt[k*5 +: 5]         = 5'(rt);
    sbif.id_read_rt[k]           = rrt;
    sbif.id_regwrite[k]          = we;
    sbif.id_wreg[k*5 +: 5]       = 5'(wr);
    sbif.id_lat[k*LAT_W +: LAT_W] = LAT_W'(lat);
  endtask

  task automatic idle();
    for (int k = 0; k < ISSUE_W; k++) set_slot(k, 0, 0, 0, 0, 0, 0, 0, 0);
    sbif.pipe_stall = 1'b0;
    sbif.flush      = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < WB_DEPTH + 1; i++) tick();
  endtask

  task automatic test_reset();
    idle();
    set_slot(0, 1, 0, 0, 0, 0, 1, 5, 3);
    sbif.flush = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    idle();
    n_chk++;
    if (sbif.hz_stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_hz: got %0d want 0", sbif.hz_stall_cycles);
    end
    set_slot(0, 1, 5, 1, 9, 1, 0, 0, 1);
    set_slot(1, 1, 7, 1, 2, 1, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.issue_ok, sbif.issue_cnt, sbif.stall_D, sbif.fwd_vld} !== {2'b11, 2'd2, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL reset_outputs: got ok=%b cnt=%0d stall=%b fv=%b want ok=11 cnt=2 stall=0 fv=0000",
                         sbif.issue_ok, sbif.issue_cnt, sbif.stall_D, sbif.fwd_vld);
    end
    idle();
  endtask

  task automatic test_fwd_alu();
    idle();
    set_slot(0, 1, 0, 0, 0, 0, 1, 5, 1);
    tick();
    idle();
    set_slot(0, 1, 5, 1, 0, 0, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_vld[0], sbif.fwd_slot[0], sbif.fwd_stage[1:0]} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL alu_fwd_E: got ok=%b fv=%b fs=%b fg=%0d want ok=1 fv=1 fs=0 fg=0",
                         sbif.issue_ok[0], sbif.fwd_vld[0], sbif.fwd_slot[0], sbif.fwd_stage[1:0]);
    end
    tick();
    n_chk++;
    if ({sbif.fwd_vld[0], sbif.fwd_stage[1:0]} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL alu_fwd_M: got fv=%b fg=%0d want fv=1 fg=1", sbif.fwd_vld[0], sbif.fwd_stage[1:0]);
    end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    logic [31:0] h0;
    drain();
    h0 = m_hz;
    set_slot(0, 1, 0, 0, 0, 0, 0, 0, 1);
    set_slot(1, 1, 0, 0, 0, 0, 1, 8, 3);
    tick();
    idle();
    set_slot(0, 1, 8, 1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if ({sbif.stall_D, sbif.issue_ok} !== {1'b1, 2'b00}) begin
        n_fail++; $display("FAIL load_use_bubble%0d: got stall=%b ok=%b want stall=1 ok=00", c, sbif.stall_D, sbif.issue_ok);
      end
      tick();
    end
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_vld[0], sbif.fwd_slot[0], sbif.fwd_stage[1:0]} !== {1'b1, 1'b1, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL load_use_issue: got ok=%b fv=%b fs=%b fg=%0d want ok=1 fv=1 fs=1 fg=2",
                         sbif.issue_ok[0], sbif.fwd_vld[0], sbif.fwd_slot[0], sbif.fwd_stage[1:0]);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (sbif.hz_stall_cycles !== h0 + 32'd2) begin
      n_fail++; $display("FAIL load_use_hz: got %0d want %0d", sbif.hz_stall_cycles, h0 + 32'd2);
    end
  endtask

  task automatic test_intra_bundle();
    drain();
    set_slot(0, 1, 0, 0, 0, 0, 1, 3, 1);
    set_slot(1, 1, 0, 0, 3, 1, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.issue_ok, sbif.issue_cnt} !== {2'b01, 2'd1}) begin
      n_fail++; $display("FAIL intra_issue: got ok=%b cnt=%0d want ok=01 cnt=1", sbif.issue_ok, sbif.issue_cnt);
    end
    tick();
    idle();
    set_slot(0, 1, 0, 0, 3, 1, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_vld[1], sbif.fwd_slot[1], sbif.fwd_stage[3:2]} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL intra_next: got ok=%b fv=%b fs=%b fg=%0d want ok=1 fv=1 fs=0 fg=0",
                         sbif.issue_ok[0], sbif.fwd_vld[1], sbif.fwd_slot[1], sbif.fwd_stage[3:2]);
    end
    tick();
    idle();
  endtask

  task automatic test_freeze();
    logic [31:0] h0;
    drain();
    h0 = m_hz;
    set_slot(0, 1, 0, 0, 0, 0, 1, 9, 3);
    tick();
    idle();
    set_slot(0, 1, 9, 1, 0, 0, 0, 0, 1);
    sbif.pipe_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++;
      if ({sbif.issue_ok, sbif.fwd_vld[0]} !== {2'b00, 1'b0}) begin
        n_fail++; $display("FAIL freeze_hold%0d: got ok=%b fv=%b want ok=00 fv=0", c, sbif.issue_ok, sbif.fwd_vld[0]);
      end
      tick();
    end
    sbif.pipe_stall = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++;
      if (sbif.stall_D !== 1'b1) begin
        n_fail++; $display("FAIL freeze_wait%0d: got stall=%b want 1", c, sbif.stall_D);
      end
      tick();
    end
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_stage[1:0], sbif.hz_stall_cycles} !== {1'b1, 2'd2, h0 + 32'd2}) begin
      n_fail++; $display("FAIL freeze_release: got ok=%b fg=%0d hz=%0d want ok=1 fg=2 hz=%0d",
                         sbif.issue_ok[0], sbif.fwd_stage[1:0], sbif.hz_stall_cycles, h0 + 32'd2);
    end
    tick();
    idle();
  endtask

  task automatic test_flush();
    drain();
    set_slot(0, 1, 0, 0, 0, 0, 1, 6, 1);
    tick();
    idle();
    tick(); tick();
    set_slot(0, 1, 0, 0, 0, 0, 1, 4, 3);
    tick();
    idle();
    set_slot(0, 1, 4, 1, 6, 1, 0, 0, 1);
    sbif.flush = 1'b1;
    #1;
    n_chk++;
    if ({sbif.issue_ok, sbif.issue_cnt} !== {2'b00, 2'd0}) begin
      n_fail++; $display("FAIL flush_blocks: got ok=%b cnt=%0d want ok=00 cnt=0", sbif.issue_ok, sbif.issue_cnt);
    end
    tick();
    sbif.flush = 1'b0;
    #1;
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_vld[1:0]} !== {1'b1, 2'b00}) begin
      n_fail++; $display("FAIL flush_after: got ok=%b fv=%b want ok=1 fv=00", sbif.issue_ok[0], sbif.fwd_vld[1:0]);
    end
    tick();
    idle();
  endtask

  task automatic test_waw();
    drain();
    set_slot(0, 1, 0, 0, 0, 0, 1, 7, 1);
    set_slot(1, 1, 0, 0, 0, 0, 1, 7, 1);
    #1;
    n_chk++;
    if (sbif.issue_ok !== 2'b11) begin
      n_fail++; $display("FAIL waw_issue: got ok=%b want 11", sbif.issue_ok);
    end
    tick();
    idle();
    set_slot(0, 1, 7, 1, 0, 0, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.fwd_vld[0], sbif.fwd_slot[0]} !== {1'b1, 1'b1}) begin
      n_fail++; $display("FAIL waw_winner: got fv=%b fs=%b want fv=1 fs=1", sbif.fwd_vld[0], sbif.fwd_slot[0]);
    end
    tick();
    set_slot(0, 1, 0, 0, 0, 0, 1, 0, 3);
    set_slot(1, 1, 0, 1, 0, 0, 0, 0, 1);
    #1;
    n_chk++;
    if (sbif.issue_ok !== 2'b11) begin
      n_fail++; $display("FAIL r0_intra: got ok=%b want 11", sbif.issue_ok);
    end
    tick();
    idle();
    set_slot(0, 1, 0, 1, 0, 1, 0, 0, 1);
    #1;
    n_chk++;
    if ({sbif.issue_ok[0], sbif.fwd_vld[1:0]} !== {1'b1, 2'b00}) begin
      n_fail++; $display("FAIL r0_never_busy: got ok=%b fv=%b want ok=1 fv=00", sbif.issue_ok[0], sbif.fwd_vld[1:0]);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      sbif.pipe_stall = ($urandom_range(0, 7) == 0);
      sbif.flush      = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < ISSUE_W; k++)
        set_slot(k, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7), $urandom_range(0, 7));
      #1;
      model_eval();
      n_chk++;
      if ({sbif.issue_ok, sbif.issue_cnt, sbif.stall_D, sbif.fwd_vld, sbif.fwd_slot, sbif.fwd_stage} !==
          {e_ok, e_cnt, e_stall, e_fv, e_fs, e_fg}) begin
        n_fail++;
        $display("FAIL rand_outputs[%0d]: got ok=%b cnt=%0d st=%b fv=%b fs=%b fg=%b want ok=%b cnt=%0d st=%b fv=%b fs=%b fg=%b",
                 i, sbif.issue_ok, sbif.issue_cnt, sbif.stall_D, sbif.fwd_vld, sbif.fwd_slot, sbif.fwd_stage,
                 e_ok, e_cnt, e_stall, e_fv, e_fs, e_fg);
      end
      n_chk++;
      if (sbif.hz_stall_cycles !== m_hz) begin
        n_fail++; $display("FAIL rand_hz[%0d]: got %0d want %0d", i, sbif.hz_stall_cycles, m_hz);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst  = 1'b1;
    adv  = 0;
    m_hz = '0;
    for (int r = 0; r < NREG; r++) begin
      m_v[r] = 0; m_t[r] = 0; m_lat[r] = 1; m_slot[r] = 0;
    end
    idle();
    #1;
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_intra_bundle();
    test_freeze();
    test_flush();
    test_waw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
